lzx_irq_prio_ctrl: RTL and testbench
====================================

LZX_IRQ_PRIO_CTRL -- requirements
Module: lzx_irq_prio_ctrl

Interface
REQ-001 SHALL provide parameter N, default 8, meaning the number of active-low request inputs; legal values are powers of two from 2 to 64.
REQ-002 SHALL provide parameter W, default $clog2(N), meaning the width of the encoded index; W is derived and not overridden.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port req_n, input, N bits: active-low request lines; bit N-1 has the highest priority.
REQ-006 SHALL provide port mask, input, N bits: 1 excludes the matching request from arbitration.
REQ-007 SHALL provide port ei_n, input, 1 bit: active-low cascade enable.
REQ-008 SHALL provide port irq_valid, output, 1 bit: a granted index is presented.
REQ-009 SHALL provide port irq_id, output, W bits: the granted index in true binary (not inverted).
REQ-010 SHALL provide port irq_ack, input, 1 bit: the consumer accepts irq_id.
REQ-011 SHALL provide port gs_n, output, 1 bit: registered, active-low "some eligible request" flag.
REQ-012 SHALL provide port eo_n, output, 1 bit: registered, active-low "enabled, none eligible" cascade output.

Function
REQ-013 SHALL register req_n into prev_q every cycle.
REQ-014 SHALL update pending_q every cycle; the update rule is set by REQ-032/033.
REQ-015 SHALL define eligible = pending_q & ~mask.
REQ-016 SHALL implement a two-state FSM with states IDLE and PRESENT.
REQ-017 In IDLE with ei_n=0 and eligible!=0, SHALL load irq_id with the highest set index of eligible and enter PRESENT.
REQ-018 In IDLE, irq_valid SHALL be 0; in PRESENT, irq_valid SHALL be 1.
REQ-019 In PRESENT, irq_id SHALL hold stable; changes to mask, ei_n or req_n SHALL NOT withdraw or alter the grant.
REQ-020 In PRESENT, irq_ack=1 SHALL return the FSM to IDLE, so the next grant is presented no earlier than 2 cycles after the ack edge.
REQ-021 irq_ack while in IDLE SHALL be ignored.
REQ-022 Latency: a request line first sampled low at edge t, eligible and highest priority, SHALL give irq_valid=1 after edge t+1.
REQ-023 When ei_n=1, gs_n SHALL register 1 and eo_n SHALL register 1.
REQ-024 When ei_n=0, gs_n SHALL register 0 iff eligible!=0, and eo_n SHALL register 0 iff eligible==0.
REQ-025 gs_n and eo_n SHALL be valid one cycle after their inputs, independent of FSM state.
REQ-026 The priority encoder SHALL scale with N and W; no hard-coded 8-input or 3-bit decoding.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-028 When rst=1 at a clock edge, irq_valid SHALL be 0 and irq_id SHALL be 0.
REQ-029 When rst=1 at a clock edge, gs_n and eo_n SHALL both be 1.
REQ-030 When rst=1 at a clock edge, pending_q SHALL be all 0 and prev_q SHALL be all 1.
REQ-031 rst asserted mid-grant (PRESENT) SHALL drop the grant without clearing any consumer state; rst takes priority over irq_ack.

Configuration
REQ-032 With macro LZX_IRQ_EDGE_EN defined, pending_q[i] SHALL set on a falling edge (prev_q[i]=1 and req_n[i]=0), stay set until cleared by an ack of index i in PRESENT, and setting SHALL win over clearing in the same cycle.
REQ-033 With LZX_IRQ_EDGE_EN undefined, pending_q SHALL equal ~req_n, registered (level mode); irq_ack SHALL NOT modify pending_q, and a line still held low SHALL be re-granted.

Verification (N=8, edge mode unless stated)
REQ-034 Stimulus: reset, then req_n=8'hFF, ei_n=0, mask=0. Required: irq_valid=0, gs_n=1, eo_n=0.
REQ-035 Stimulus: req_n drops to 8'h5F (bits 7 and 5 low). Required: irq_id=7 and irq_valid=1 two edges later; hold with no ack -> irq_id stays 7; ack -> IDLE, then irq_id=5.
REQ-036 Stimulus: mask=8'h80 while bits 7 and 5 are pending. Required: grant irq_id=5; gs_n=0.
REQ-037 Stimulus: ei_n=1 with pending requests. Required: no new grant; gs_n=1, eo_n=1; an existing PRESENT grant is held until ack.
REQ-038 Stimulus: a new falling edge on bit 3 in the same cycle as ack of irq_id=3. Required: bit 3 pending stays set and is re-granted.
REQ-039 Stimulus: level mode (macro undefined), req_n[2] held low. Ack each grant. Required: irq_id=2 re-granted every 2 cycles; rst in PRESENT gives irq_valid=0 on the next edge.

Source files
------------

// File: rtl/lzx_irq_prio_ctrl.sv
// ---------------------------------------------------------------------------
// lzx_irq_prio_ctrl
//
// Purpose
//   Registered, cascadable priority interrupt controller. It works like a
//   clocked 74x148-style priority encoder with a grant handshake. N active-low
//   request lines are captured into a pending vector. Masked lines are
//   removed. The highest set index is then presented to a consumer as a
//   binary id. The id is held stable until the consumer acknowledges it.
//   The gs_n / eo_n flags give the usual encoder cascade outputs, registered
//   one cycle after their inputs.
//
// Configuration
//   LZX_IRQ_EDGE_EN  When defined, a falling edge on a request line sets its
//                    pending bit. The bit stays set until the grant of that
//                    index is acknowledged, and a new edge in the ack cycle
//                    wins over the clear.
//                    When undefined (default), the controller runs in level
//                    mode: pending is the registered inverse of req_n, ack
//                    does not touch it, and a line still held low is
//                    granted again.
//
// Parameters
//   N  number of request lines; a power of two from 2 to 64 (default 8)
//   W  encoded index width, $clog2(N); derived, do not override
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   req_n      in   [N-1:0] active-low requests, bit N-1 = highest priority
//   mask       in   [N-1:0] 1 = exclude the matching request from arbitration
//   ei_n       in   active-low cascade enable
//   irq_valid  out  a granted index is presented on irq_id
//   irq_id     out  [W-1:0] granted index, true binary
//   irq_ack    in   consumer accepts irq_id (ignored when nothing is presented)
//   gs_n       out  registered, active-low "enabled and some eligible request"
//   eo_n       out  registered, active-low "enabled and none eligible"
// ---------------------------------------------------------------------------
module lzx_irq_prio_ctrl #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_n,
    input  logic [N-1:0] mask,
    input  logic         ei_n,
    output logic         irq_valid,
    output logic [W-1:0] irq_id,
    input  logic         irq_ack,
    output logic         gs_n,
    output logic         eo_n
);

    // -----------------------------------------------------------------------
    // Types and state
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   prev_q;       // req_n as sampled on the previous edge
    logic [N-1:0]   pending_q;    // captured requests, active-high
    logic [N-1:0]   pending_d;
    logic [W-1:0]   irq_id_q;
    logic           irq_valid_q;
    logic           gs_n_q;
    logic           gs_n_d;
    logic           eo_n_q;
    logic           eo_n_d;

    logic [N-1:0]   eligible;
    logic           any_eligible;
    logic [W-1:0]   enc_idx;

    // -----------------------------------------------------------------------
    // Arbitration inputs
    // -----------------------------------------------------------------------
    assign eligible     = pending_q & ~mask;
    assign any_eligible = |eligible;

    // Priority encoder. The loop runs from low to high index, so the last
    // hit is the highest set bit. It scales with N and W without any
    // per-width decode table.
    // NOTE: every signal written in an always_comb gets a default value
    // first. A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                enc_idx = W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending vector next state
    // -----------------------------------------------------------------------
`ifdef LZX_IRQ_EDGE_EN
    logic [N-1:0] fall;       // 1 -> 0 transition seen on this edge
    logic [N-1:0] ack_clr;    // one-hot clear of the acknowledged index

    assign fall = prev_q & ~req_n;

    always_comb begin
        ack_clr = '0;
        if (state_q == PRESENT && irq_ack) begin
            ack_clr[irq_id_q] = 1'b1;
        end
    end

    // The set term comes after the clear term. A new falling edge in the
    // same cycle as the ack of that index therefore keeps the bit pending.
    assign pending_d = (pending_q & ~ack_clr) | fall;
`else
    // Level mode: pending mirrors the request lines one cycle late. An ack
    // has no effect here, so a line still held low competes again.
    assign pending_d = ~req_n;
`endif

    // -----------------------------------------------------------------------
    // Cascade flags next state. These depend only on ei_n and on what is
    // eligible now; they do not depend on the grant FSM.
    // -----------------------------------------------------------------------
    always_comb begin
        gs_n_d = 1'b1;
        eo_n_d = 1'b1;
        if (!ei_n) begin
            gs_n_d = ~any_eligible;
            eo_n_d = any_eligible;
        end
    end

    // -----------------------------------------------------------------------
    // Request capture and cascade flag registers
    // -----------------------------------------------------------------------
    // NOTE: clocked state is updated with non-blocking (<=) assignments.
    // Every flop then samples the values from before the edge, whatever
    // order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '1;
            pending_q <= '0;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
        end else begin
            prev_q    <= req_n;
            pending_q <= pending_d;
            gs_n_q    <= gs_n_d;
            eo_n_q    <= eo_n_d;
        end
    end

    // -----------------------------------------------------------------------
    // Grant FSM with registered outputs.
    // IDLE    : wait for the cascade enable and an eligible request, then
    //           latch the encoded index and present it.
    // PRESENT : hold irq_id until the ack. Mask, enable and request changes
    //           do not withdraw or alter the grant. After the ack, the FSM
    //           spends one cycle in IDLE, so the next grant comes no sooner
    //           than two edges after the ack edge.
    // Reset wins over the ack and drops any grant in flight.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            irq_id_q    <= '0;
            irq_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ei_n && any_eligible) begin
                        irq_id_q    <= enc_idx;
                        irq_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    irq_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign gs_n      = gs_n_q;
    assign eo_n      = eo_n_q;

endmodule

// File: tb/tb_lzx_irq_prio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lzx_irq_prio_ctrl
//
// Directed bench for lzx_irq_prio_ctrl with N=8. Each table row holds the
// inputs driven for one clock cycle and the outputs expected after the next
// rising edge. The row set follows the build: level mode by default, edge
// mode when LZX_IRQ_EDGE_EN is defined. A short hand-written sequence after
// the table covers the lowest-priority line, the measured grant latency and
// a fully masked controller.
// ---------------------------------------------------------------------------
module tb_lzx_irq_prio_ctrl;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_n;
    logic [N-1:0] mask;
    logic         ei_n;
    logic         irq_valid;
    logic [W-1:0] irq_id;
    logic         irq_ack;
    logic         gs_n;
    logic         eo_n;

    lzx_irq_prio_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_n     (req_n),
        .mask      (mask),
        .ei_n      (ei_n),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .gs_n      (gs_n),
        .eo_n      (eo_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req_n;
        logic [N-1:0] mask;
        logic         ei_n;
        logic         ack;
        logic         exp_valid;
        logic [W-1:0] exp_id;
        logic         exp_gs_n;
        logic         exp_eo_n;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] m,
                       input logic e, input logic a, input logic v, input logic [W-1:0] id,
                       input logic g, input logic eo);
        vec_t t;
        t.rst = r; t.req_n = rq; t.mask = m; t.ei_n = e; t.ack = a;
        t.exp_valid = v; t.exp_id = id; t.exp_gs_n = g; t.exp_eo_n = eo;
        tbl.push_back(t);
    endtask

    // Advance one rising edge. Outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_n = '1; mask = '0; ei_n = 1'b0; irq_ack = 1'b0;

        //   rst req_n  mask   ei ack | valid id gs eo
`ifdef LZX_IRQ_EDGE_EN
        add(1, 8'hFF, 8'h00, 0, 0,   0, 0, 1, 1);  // reset values
        add(0, 8'hFF, 8'h00, 0, 0,   0, 0, 1, 0);  // idle, nothing eligible
        add(0, 8'h5F, 8'h00, 0, 0,   0, 0, 1, 0);  // bits 7,5 fall
        add(0, 8'h5F, 8'h00, 0, 0,   1, 7, 0, 1);  // grant 7, 2 edges later
        add(0, 8'h5F, 8'h00, 0, 0,   1, 7, 0, 1);  // held without ack
        add(0, 8'h5F, 8'h00, 0, 1,   0, 7, 0, 1);  // ack clears 7
        add(0, 8'h5F, 8'h00, 0, 0,   1, 5, 0, 1);  // grant 5
        add(0, 8'h5F, 8'h00, 0, 1,   0, 5, 0, 1);  // ack clears 5
        add(0, 8'hFF, 8'h00, 0, 0,   0, 5, 1, 0);  // release, nothing pending
        add(0, 8'h5F, 8'h80, 0, 0,   0, 5, 1, 0);  // 7,5 fall, 7 masked
        add(0, 8'h5F, 8'h80, 0, 0,   1, 5, 0, 1);  // grant 5 under mask
        add(0, 8'h5F, 8'h80, 0, 1,   0, 5, 0, 1);  // ack 5, 7 still pending
        add(0, 8'h5F, 8'h00, 1, 0,   0, 5, 1, 1);  // disabled: no grant
        add(0, 8'h5F, 8'h00, 1, 0,   0, 5, 1, 1);
        add(0, 8'h5F, 8'h00, 0, 0,   1, 7, 0, 1);  // enabled: grant 7
        add(0, 8'h5F, 8'h00, 1, 0,   1, 7, 1, 1);  // disable holds grant
        add(0, 8'h5F, 8'h00, 0, 1,   0, 7, 0, 1);  // ack
        add(0, 8'hFF, 8'h00, 0, 0,   0, 7, 1, 0);
        add(0, 8'hF7, 8'h00, 0, 0,   0, 7, 1, 0);  // bit 3 falls
        add(0, 8'hF7, 8'h00, 0, 0,   1, 3, 0, 1);  // grant 3
        add(0, 8'hFF, 8'h00, 0, 0,   1, 3, 0, 1);  // bit 3 released
        add(0, 8'hF7, 8'h00, 0, 1,   0, 3, 0, 1);  // new fall + ack of 3
        add(0, 8'hF7, 8'h00, 0, 0,   1, 3, 0, 1);  // 3 re-granted
        add(1, 8'hF7, 8'h00, 0, 1,   0, 0, 1, 1);  // rst beats ack
        add(0, 8'hF7, 8'h00, 0, 0,   0, 0, 1, 0);  // held-low line re-arms
        add(0, 8'hF7, 8'h00, 0, 0,   1, 3, 0, 1);
`else
        add(1, 8'hFF, 8'h00, 0, 0,   0, 0, 1, 1);  // reset values
        add(0, 8'hFF, 8'h00, 0, 0,   0, 0, 1, 0);  // idle, nothing eligible
        add(0, 8'h5F, 8'h00, 0, 0,   0, 0, 1, 0);  // bits 7,5 low
        add(0, 8'h5F, 8'h00, 0, 0,   1, 7, 0, 1);  // grant 7, 2 edges later
        add(0, 8'h5F, 8'h00, 0, 0,   1, 7, 0, 1);  // held without ack
        add(0, 8'hDF, 8'h00, 0, 1,   0, 7, 0, 1);  // ack, release 7
        add(0, 8'hDF, 8'h00, 0, 0,   1, 5, 0, 1);  // grant 5
        add(0, 8'h5F, 8'h80, 0, 1,   0, 5, 0, 1);  // ack, 7 low again, masked
        add(0, 8'h5F, 8'h80, 0, 0,   1, 5, 0, 1);  // mask hides 7 -> 5
        add(0, 8'h7F, 8'h00, 1, 0,   1, 5, 1, 1);  // changes do not alter grant
        add(0, 8'h7F, 8'h00, 1, 1,   0, 5, 1, 1);  // ack
        add(0, 8'h7F, 8'h00, 1, 0,   0, 5, 1, 1);  // disabled: no grant
        add(0, 8'h7F, 8'h00, 0, 0,   1, 7, 0, 1);  // enabled: grant 7
        add(0, 8'hFF, 8'h00, 0, 1,   0, 7, 0, 1);  // ack, release
        add(0, 8'hFF, 8'h00, 0, 1,   0, 7, 1, 0);  // ack in IDLE ignored
        add(0, 8'hFB, 8'h00, 0, 0,   0, 7, 1, 0);  // bit 2 held low
        add(0, 8'hFB, 8'h00, 0, 0,   1, 2, 0, 1);
        add(0, 8'hFB, 8'h00, 0, 1,   0, 2, 0, 1);  // ack every cycle:
        add(0, 8'hFB, 8'h00, 0, 1,   1, 2, 0, 1);  // re-grant every 2 cycles
        add(0, 8'hFB, 8'h00, 0, 1,   0, 2, 0, 1);
        add(0, 8'hFB, 8'h00, 0, 1,   1, 2, 0, 1);
        add(1, 8'hFB, 8'h00, 0, 0,   0, 0, 1, 1);  // rst in PRESENT
        add(0, 8'hFB, 8'h00, 0, 0,   0, 0, 1, 0);
        add(0, 8'hFB, 8'h00, 0, 0,   1, 2, 0, 1);
        add(1, 8'hFB, 8'h00, 0, 1,   0, 0, 1, 1);  // rst beats ack
        add(0, 8'hFF, 8'h00, 0, 0,   0, 0, 1, 0);
`endif

        #1;
        foreach (tbl[k]) begin
            rst = tbl[k].rst; req_n = tbl[k].req_n; mask = tbl[k].mask;
            ei_n = tbl[k].ei_n; irq_ack = tbl[k].ack;
            step();
            check($sformatf("vec%0d irq_valid", k), 32'(irq_valid), 32'(tbl[k].exp_valid));
            check($sformatf("vec%0d irq_id", k),    32'(irq_id),    32'(tbl[k].exp_id));
            check($sformatf("vec%0d gs_n", k),      32'(gs_n),      32'(tbl[k].exp_gs_n));
            check($sformatf("vec%0d eo_n", k),      32'(eo_n),      32'(tbl[k].exp_eo_n));
        end

        // Lowest-priority line: measure the grant latency with a bounded wait.
        rst = 1'b1; req_n = '1; mask = '0; ei_n = 1'b0; irq_ack = 1'b0;
        step();
        rst = 1'b0; req_n = 8'hFE;
        begin
            int lat = 0;
            while (!irq_valid && lat < 10) begin
                step();
                lat++;
            end
            check("bit0 grant latency", 32'(lat), 32'd2);
            check("bit0 irq_id", 32'(irq_id), 32'd0);
        end

        // Fully masked: after the ack, nothing may be granted, and the
        // cascade flags report "enabled, none eligible".
        mask = 8'hFF; irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("masked idle valid c%0d", c), 32'(irq_valid), 32'd0);
        end
        check("masked gs_n", 32'(gs_n), 32'd1);
        check("masked eo_n", 32'(eo_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
